// File: rtl/matrix_pkg.sv
// Shared widths, loader state encoding and element-slot indices for the
// 2x2 matrix adder datapath.
package matrix_pkg;

  localparam int ELEM_W  = 3;
  localparam int RES_W   = 4;
  localparam int N_ELEMS = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } ld_state_t;

  // Row-major, A then B.
  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

endpackage

// File: rtl/matrix_operand_bank.sv
// Register bank of N_SLOTS elements: indexed single-slot write, or a whole-bank
// copy that takes priority over the write. Reset clears every slot.
module matrix_operand_bank #(
  parameter int ELEM_W  = 3,
  parameter int N_SLOTS = 8,
  localparam int IW     = $clog2(N_SLOTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [IW-1:0]                  widx,
  input  logic [ELEM_W-1:0]              wdata,
  input  logic                           copy_en,
  input  logic [N_SLOTS-1:0][ELEM_W-1:0] copy_src,
  output logic [N_SLOTS-1:0][ELEM_W-1:0] q
);

  // Clear, bulk copy, or single-slot write, in that priority.
  always_ff @(posedge clk) begin
    if (rst)          q       <= '0;
    else if (copy_en) q       <= copy_src;
    else if (we)      q[widx] <= wdata;
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for the 2x2 matrix adder. Eight elements
// arrive over valid/ready (A row-major, then B row-major) and are presented
// together with out_valid until out_ready acknowledges the set.
// Optional build macro MATRIX_LOADER_DOUBLE_BUF_EN: operands come from a
// separate output bank committed whole on the 8th transfer, so the outputs
// never show a partially loaded set.
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = matrix_pkg::ELEM_W,
  parameter int N_ELEMS = matrix_pkg::N_ELEMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ELEM_W-1:0] a11,
  output logic [ELEM_W-1:0] a12,
  output logic [ELEM_W-1:0] a21,
  output logic [ELEM_W-1:0] a22,
  output logic [ELEM_W-1:0] b11,
  output logic [ELEM_W-1:0] b12,
  output logic [ELEM_W-1:0] b21,
  output logic [ELEM_W-1:0] b22,
  output logic [2:0]        elem_idx
);

  localparam int N_SLOTS = 2 * N_ELEMS;

  ld_state_t state;
  logic      xfer;
  logic      last_xfer;

  logic [N_SLOTS-1:0][ELEM_W-1:0] stage_q;
  logic [N_SLOTS-1:0][ELEM_W-1:0] ops;

  assign in_ready  = (state != HOLD);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (elem_idx == IDX_B22);

  // Loader FSM: slot index, state and out_valid all registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      elem_idx  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (xfer) begin
          elem_idx <= elem_idx + 3'd1;
          if (elem_idx == IDX_A22) state <= LOAD_B;
        end
        LOAD_B: if (xfer) begin
          if (elem_idx == IDX_B22) begin
            elem_idx  <= '0;
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            elem_idx <= elem_idx + 3'd1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= LOAD_A;
          out_valid <= 1'b0;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  matrix_operand_bank #(.ELEM_W(ELEM_W), .N_SLOTS(N_SLOTS)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .we       (xfer),
    .widx     (elem_idx),
    .wdata    (in_data),
    .copy_en  (1'b0),
    .copy_src ('0),
    .q        (stage_q)
  );

`ifdef MATRIX_LOADER_DOUBLE_BUF_EN
  logic [N_SLOTS-1:0][ELEM_W-1:0] stage_next;

  // Staging contents including the element landing this cycle, so the
  // commit on the 8th transfer captures the complete set.
  always_comb begin
    stage_next = stage_q;
    if (xfer) stage_next[elem_idx] = in_data;
  end

  matrix_operand_bank #(.ELEM_W(ELEM_W), .N_SLOTS(N_SLOTS)) u_out (
    .clk      (clk),
    .rst      (rst),
    .we       (1'b0),
    .widx     ('0),
    .wdata    ('0),
    .copy_en  (last_xfer),
    .copy_src (stage_next),
    .q        (ops)
  );
`else
  logic unused_last;
  assign unused_last = last_xfer;
  assign ops         = stage_q;
`endif

  assign a11 = ops[IDX_A11];
  assign a12 = ops[IDX_A12];
  assign a21 = ops[IDX_A21];
  assign a22 = ops[IDX_A22];
  assign b11 = ops[IDX_B11];
  assign b12 = ops[IDX_B12];
  assign b21 = ops[IDX_B21];
  assign b22 = ops[IDX_B22];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed scenarios plus a random phase,
// all outputs compared every cycle against a set-level reference model.
module tb_matrix_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       in_ready;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic [2:0] elem_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: elements collected so far in this set, the visible
  // operand set, and whether a complete set is awaiting acknowledge.
  logic [2:0] m_stage [8];
  logic [2:0] m_out   [8];
  int         m_cnt;
  bit         m_hold;

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22), .elem_idx(elem_idx)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [2:0] got [8];
    logic [2:0] vis;
    got[0] = a11; got[1] = a12; got[2] = a21; got[3] = a22;
    got[4] = b11; got[5] = b12; got[6] = b21; got[7] = b22;
    chk("in_ready", {7'd0, in_ready}, {7'd0, !m_hold});
    chk("out_valid", {7'd0, out_valid}, {7'd0, m_hold});
    chk("elem_idx", {5'd0, elem_idx}, 8'(m_cnt));
    for (int i = 0; i < 8; i++) begin
`ifdef MATRIX_LOADER_DOUBLE_BUF_EN
      vis = m_out[i];
`else
      vis = m_stage[i];
`endif
      chk($sformatf("operand[%0d]", i), {5'd0, got[i]}, {5'd0, vis});
    end
  endtask

  // One clock: apply inputs, advance the model by the same edge, compare.
  task automatic cyc(input bit v, input logic [2:0] d, input bit ordy, input bit r);
    in_valid = v; in_data = d; out_ready = ordy; rst = r;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) begin m_stage[i] = '0; m_out[i] = '0; end
      m_cnt = 0; m_hold = 0;
    end else if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (v) begin
      m_stage[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 8) begin
        for (int i = 0; i < 8; i++) m_out[i] = m_stage[i];
        m_cnt = 0; m_hold = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic send_set(input logic [2:0] vals [8], input int gap);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) cyc(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      cyc(1'b1, vals[i], 1'b0, 1'b0);
    end
  endtask

  task automatic chk_ops(input string tag, input logic [2:0] e [8]);
    chk({tag, "_a11"}, {5'd0, a11}, {5'd0, e[0]});
    chk({tag, "_a12"}, {5'd0, a12}, {5'd0, e[1]});
    chk({tag, "_a21"}, {5'd0, a21}, {5'd0, e[2]});
    chk({tag, "_a22"}, {5'd0, a22}, {5'd0, e[3]});
    chk({tag, "_b11"}, {5'd0, b11}, {5'd0, e[4]});
    chk({tag, "_b12"}, {5'd0, b12}, {5'd0, e[5]});
    chk({tag, "_b21"}, {5'd0, b21}, {5'd0, e[6]});
    chk({tag, "_b22"}, {5'd0, b22}, {5'd0, e[7]});
  endtask

  initial begin
    logic [2:0] s_up   [8];
    logic [2:0] s_down [8];
    logic [2:0] s_three[8];
    for (int i = 0; i < 8; i++) begin
      s_up[i]    = 3'(i + 1);
      s_down[i]  = 3'(7 - i);
      s_three[i] = 3'd3;
      m_stage[i] = 'x; m_out[i] = 'x;
    end
    m_cnt = 0; m_hold = 0;

    // Reset state
    cyc(1'b1, 3'd5, 1'b0, 1'b1);
    cyc(1'b1, 3'd6, 1'b0, 1'b1);

    // Back-to-back stream 1..7,0; HOLD entered right after 8th transfer
    send_set(s_up, 0);
    chk("hold_valid", {7'd0, out_valid}, 8'd1);
    chk("hold_ready", {7'd0, in_ready}, 8'd0);
    chk_ops("set1", s_up);

    // HOLD with in_valid=1/in_data=7 and no ack: nothing moves
    for (int i = 0; i < 10; i++) cyc(1'b1, 3'd7, 1'b0, 1'b0);
    chk_ops("hold10", s_up);
    chk("hold_idx", {5'd0, elem_idx}, 8'd0);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    chk("ack_valid", {7'd0, out_valid}, 8'd0);
    chk("ack_ready", {7'd0, in_ready}, 8'd1);

    // Same stream with 3-cycle gaps
    send_set(s_up, 3);
    chk_ops("gapped", s_up);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Partial load then reset discards it
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd7, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("rst_idx", {5'd0, elem_idx}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_a11", {5'd0, a11}, 8'd0);
    send_set(s_three, 0);
    chk_ops("threes", s_three);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Two consecutive sets with ack between
    send_set(s_up, 1);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    send_set(s_down, 0);
    chk_ops("set2", s_down);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Random traffic, occasional resets, random acks
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 79) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
